// File: rtl/word_fifo.sv
// Word FIFO behind the byte packer: first-word fall-through buffer with
// drop-on-full write policy, sticky overflow flag and saturating drop counter.
module word_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  localparam int AW      = $clog2(DEPTH),
  parameter int AF_LEVEL = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             wr_accept, wr_drop, rd_accept;

  // Status is derived from the registered pointers only, so it tracks the
  // same edge that moves a pointer and follows an async reset immediately.
  assign full        = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty       = (wp_q == rp_q);
  assign count       = wp_q - rp_q;
  assign almost_full = (count >= AF_THRESH);
  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign rd_data     = mem_q[rp_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

  assign wr_accept = wr_valid && !full;
  assign wr_drop   = wr_valid && full;
  assign rd_accept = rd_ready && !empty;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_accept) wp_d = wp_q + PTR_ONE;
    if (rd_accept) rp_d = rp_q + PTR_ONE;
    if (wr_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset; a full FIFO never overwrites a slot.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wp_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_word_fifo.sv
// Directed bench for word_fifo: fill/drain, overflow, wrap under streaming,
// full-plus-read, empty read with fall-through, and mid-operation reset.
module tb_word_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  word_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " count"}, 32'(count), 32'd0);
    checkOutput({tag, " empty"}, 32'(empty), 32'd1);
    checkOutput({tag, " full"}, 32'(full), 32'd0);
    checkOutput({tag, " almost_full"}, 32'(almost_full), 32'd0);
    checkOutput({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, " wr_ready"}, 32'(wr_ready), 32'd1);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    #12;
    checkResetState("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Fill 1..8 with no reads
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i);
      tick();
      checkOutput($sformatf("fill count %0d", i), 32'(count), 32'(i));
      checkOutput($sformatf("fill almost_full %0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
    end
    wr_valid = 1'b0;
    checkOutput("full after fill", 32'(full), 32'd1);
    checkOutput("wr_ready after fill", 32'(wr_ready), 32'd0);
    checkOutput("head after fill", rd_data, 32'd1);

    // Three dropped writes while full
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) tick();
    wr_valid = 1'b0;
    checkOutput("overflow set", 32'(overflow), 32'd1);
    checkOutput("drop_cnt 3", 32'(drop_cnt), 32'd3);
    checkOutput("count after drops", 32'(count), 32'd8);

    // Full plus read: the read wins, the write is dropped
    wr_valid = 1'b1; wr_data = 32'hA5A5_A5A5; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    checkOutput("full+read count", 32'(count), 32'd7);
    checkOutput("full+read drop_cnt", 32'(drop_cnt), 32'd4);
    checkOutput("full+read head", rd_data, 32'd2);

    // Drain the remaining original words
    for (int i = 2; i <= 8; i++) begin
      checkOutput($sformatf("drain valid %0d", i), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("drain data %0d", i), rd_data, 32'(i));
      tick();
    end
    checkOutput("empty after drain", 32'(empty), 32'd1);
    checkOutput("count after drain", 32'(count), 32'd0);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);

    // Reading while empty changes nothing
    tick(); tick();
    checkOutput("empty read count", 32'(count), 32'd0);
    checkOutput("empty read empty", 32'(empty), 32'd1);

    // Fall-through with rd_ready still high
    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    tick();
    wr_valid = 1'b0;
    checkOutput("fwft rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("fwft rd_data", rd_data, 32'h1234_5678);
    checkOutput("fwft count", 32'(count), 32'd1);
    tick();
    checkOutput("fwft empty again", 32'(empty), 32'd1);

    // Stream at count=4 across pointer wrap
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 32'h100 + 32'(i);
      tick();
    end
    checkOutput("stream start count", 32'(count), 32'd4);
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_valid = 1'b1; wr_data = 32'h104 + 32'(k);
      checkOutput($sformatf("stream data %0d", k), rd_data, 32'h100 + 32'(k));
      tick();
      checkOutput($sformatf("stream count %0d", k), 32'(count), 32'd4);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("stream tail %0d", k), rd_data, 32'h114 + 32'(k));
      tick();
    end
    checkOutput("stream empty", 32'(empty), 32'd1);

    // Reach count=5, drop_cnt=2, then reset between edges
    rd_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("re-reset drop_cnt", 32'(drop_cnt), 32'd0);
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 32'h200 + 32'(i);
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rd_ready = 1'b0;
    checkOutput("pre-reset count", 32'(count), 32'd5);
    checkOutput("pre-reset drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("pre-reset head", rd_data, 32'h203);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("mid reset");
    #2;
    rst_n = 1'b1;
    tick();
    wr_valid = 1'b1; wr_data = 32'hCAFE_0001;
    tick();
    wr_valid = 1'b0;
    checkOutput("post-reset rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("post-reset rd_data", rd_data, 32'hCAFE_0001);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checkOutput("post-reset empty", 32'(empty), 32'd1);

    // Drop counter saturates at 255
    wr_valid = 1'b1; wr_data = 32'h55;
    for (int i = 0; i < 8 + 260; i++) tick();
    wr_valid = 1'b0;
    checkOutput("drop_cnt saturate", 32'(drop_cnt), 32'd255);
    checkOutput("saturate count", 32'(count), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/word_fifo.md
# word_fifo

Buffers the 32-bit words produced by the byte-to-word shift-register packer. Each packer `valid_fifo` pulse writes one word. A downstream consumer drains the words through a valid/ready handshake. The block sits directly downstream of the packer and absorbs rate mismatch. Because the packer ignores backpressure, writes that arrive while the FIFO is full are dropped and counted.

## Interface
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 8, number of entries; must be a power of two and at least 2.
- `AW`, log2(DEPTH) = 3, pointer width; derived, do not override.
- `AF_LEVEL`, 6, `almost_full` asserts when `count` ≥ `AF_LEVEL`.

Clocking and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_data`  in  WIDTH  word from the packer.
- `wr_valid`  in  1  write strobe, driven by the packer's `valid_fifo`; one word per high cycle.
- `wr_ready`  out  1  equals `!full`; advisory only.
- `rd_data`  out  WIDTH  word at the head of the FIFO.
- `rd_valid`  out  1  equals `!empty`.
- `rd_ready`  in  1  consumer accepts `rd_data` this cycle.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  `count >= AF_LEVEL`.
- `overflow`  out  1  sticky; set on the first dropped write.
- `drop_cnt`  out  8  number of dropped writes; saturates at 255.

## Operation
- Storage is a DEPTH×WIDTH register array. Write pointer `wp` and read pointer `rp` are each AW+1 bits wide; the MSB is the wrap bit.
- `full` = (`wp[AW]` != `rp[AW]`) and (`wp[AW-1:0]` == `rp[AW-1:0]`). `empty` = (`wp` == `rp`). `count` = `wp - rp`, computed modulo 2^(AW+1).
- Write accept = `wr_valid & !full`. The full check uses the pre-edge state. On accept, `mem[wp[AW-1:0]]` ← `wr_data` and `wp` ← `wp+1`.
- Dropped write = `wr_valid & full`. On a drop, `overflow` ← 1 and `drop_cnt` ← min(`drop_cnt`+1, 255). Stored data and pointers are unchanged.
- Read accept = `rd_ready & !empty`. On accept, `rp` ← `rp+1`. `rd_ready` while empty has no effect.
- `rd_data` = `mem[rp[AW-1:0]]`, first-word fall-through. `rd_data` is don't-care while empty and is not checked when `rd_valid` is 0.
- Simultaneous write and read while neither full nor empty: both are accepted and `count` is unchanged.
- Simultaneous write and read while full: the read is accepted and the write is dropped. There is no same-cycle pass-through of a freed slot.
- Simultaneous write and read while empty: the write is accepted and the read is ignored.
- Pointers wrap naturally through 2^(AW+1). No explicit wrap logic is needed beyond the fixed width.
- `overflow` and `drop_cnt` clear only on reset.

## Timing
- Reset (asynchronous assert, release on `clk`): `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `rd_valid`=0, `wr_ready`=1, `overflow`=0, `drop_cnt`=0. Array contents are not reset.
- Write latency: a word accepted at edge N appears on `rd_data` with `rd_valid`=1 in the cycle after edge N, when the FIFO was empty. The minimum throughput latency is therefore 1 cycle.
- Status outputs (`count`, `full`, `empty`, `almost_full`, `overflow`, `drop_cnt`) update at the same edge as the event that causes them. They are registered, or derived combinationally from registered pointers only.
- Sustained throughput is one write and one read per cycle.
- Reset asserted mid-operation: all state listed above clears immediately. Buffered words are discarded.

## Test plan
- **Fill and drain:** write 0x0000_0001..0x0000_0008 on consecutive cycles with `rd_ready`=0. Required: `full`=1, `count`=8, `almost_full` rises after the 6th write. Then hold `rd_ready`=1. Required: the reads return 1..8 in order, and `empty`=1 after the 8th read.
- **Overflow:** with the FIFO full, pulse `wr_valid` 3 times with 0xDEAD_BEEF. Required: `overflow`=1, `drop_cnt`=3, and a subsequent drain returns the original 8 words with no 0xDEAD_BEEF.
- **Simultaneous:** at `count`=4, assert both `wr_valid` and `rd_ready` for 20 cycles with an incrementing pattern. Required: `count` stays 4 and the output order is preserved across pointer wrap.
- **Full plus read:** at `count`=8, write 0xA5A5_A5A5 together with `rd_ready`=1. Required: one word is read, the write is dropped, `count`=7, and `drop_cnt` increments.
- **Empty read and fall-through:** with the FIFO empty, hold `rd_ready`=1. Required: `rp` stays unchanged. Then write 0x1234_5678 at edge N. Required: `rd_valid`=1 and `rd_data`=0x1234_5678 in cycle N+1, and `empty`=1 again after N+1.
- **Reset mid-operation:** at `count`=5 with `drop_cnt`=2, drive `rst_n` low asynchronously between edges. Required: all outputs immediately take their reset values, and a post-reset write/read works normally.
